// File: rtl/vga_sync_monitor.sv
// Receive-side VGA sync monitor: synchronises hsync/vsync, measures line and
// frame timing in pixel ticks / lines, and reports lock once timing is stable.
module vga_sync_monitor #(
  parameter int H_W              = 11,
  parameter int V_W              = 10,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  input  logic           hsync_in,
  input  logic           vsync_in,
  output logic [H_W-1:0] h_total,
  output logic [H_W-1:0] h_sync_len,
  output logic [V_W-1:0] v_total,
  output logic [V_W-1:0] v_sync_len,
  output logic [H_W-1:0] hpos,
  output logic [V_W-1:0] vpos,
  output logic           line_start,
  output logic           frame_start,
  output logic           locked,
  output logic           timeout_err,
  output logic [1:0]     lock_state_o
);

  localparam logic           ACT       = SYNC_ACTIVE_HIGH;
  localparam logic [H_W-1:0] H_ONE     = 1;
  localparam logic [V_W-1:0] V_ONE     = 1;
  localparam logic [1:0]     ST_SEARCH = 2'd0;
  localparam logic [1:0]     ST_TRACK  = 2'd1;
  localparam logic [1:0]     ST_LOCKED = 2'd2;

  logic           h_meta_q, h_sync_q, v_meta_q, v_sync_q;
  logic           s_h, s_v;
  logic           h_prev_q, v_prev_q, h_seen_q, v_seen_q;
  logic [H_W-1:0] hcnt_q, hcnt_inc, h_total_q, h_sync_len_q;
  logic [V_W-1:0] vcnt_q, vcnt_inc, v_total_q, v_sync_len_q;
  logic           line_start_q, frame_start_q, locked_q;
  logic           h_lead, h_trail, v_lead, v_trail;
  logic           h_mismatch, v_mismatch;
  logic [1:0]     state_q, state_d;
  logic           line_bad_q, line_bad_d, first_q, first_d, vtrk_q, vtrk_d;

  // Normalise polarity so 1 always means "pulse active".
  assign s_h      = ~(h_sync_q ^ ACT);
  assign s_v      = ~(v_sync_q ^ ACT);
  assign hcnt_inc = hcnt_q + H_ONE;
  assign vcnt_inc = vcnt_q + V_ONE;
  assign h_lead   = pix_en & s_h & ~h_prev_q;
  assign h_trail  = pix_en & ~s_h & h_prev_q;
  // The vertical axis only advances on horizontal leading edges.
  assign v_lead   = h_lead & s_v & ~v_prev_q;
  assign v_trail  = h_lead & ~s_v & v_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_meta_q <= ~ACT;
      h_sync_q <= ~ACT;
      v_meta_q <= ~ACT;
      v_sync_q <= ~ACT;
    end else begin
      h_meta_q <= hsync_in;
      h_sync_q <= h_meta_q;
      v_meta_q <= vsync_in;
      v_sync_q <= v_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_prev_q      <= 1'b0;
      v_prev_q      <= 1'b0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      h_total_q     <= '0;
      h_sync_len_q  <= '0;
      v_total_q     <= '0;
      v_sync_len_q  <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= h_lead;
      frame_start_q <= v_lead;
      if (pix_en) begin
        h_prev_q <= s_h;
        if (h_lead) begin
          hcnt_q <= '0;
          if (h_seen_q) h_total_q <= hcnt_inc;
          else          h_seen_q  <= 1'b1;
        end else if (!(&hcnt_q)) begin
          hcnt_q <= hcnt_inc;
        end
        if (h_trail && h_seen_q) h_sync_len_q <= hcnt_inc;
      end
      if (h_lead) begin
        v_prev_q <= s_v;
        if (v_lead) begin
          vcnt_q <= '0;
          if (v_seen_q) v_total_q <= vcnt_inc;
          else          v_seen_q  <= 1'b1;
        end else if (!(&vcnt_q)) begin
          vcnt_q <= vcnt_inc;
        end
        if (v_trail && v_seen_q) v_sync_len_q <= vcnt_inc;
      end
    end
  end

  assign h_mismatch = h_lead & h_seen_q & (hcnt_inc != h_total_q);
  assign v_mismatch = v_lead & (vcnt_inc != v_total_q);

  // vtrk marks that a v_total was captured since entering TRACK, so lock
  // needs two consecutive in-TRACK frame measurements that agree.
  always_comb begin
    state_d    = state_q;
    line_bad_d = line_bad_q;
    first_d    = first_q;
    vtrk_d     = vtrk_q;
    case (state_q)
      ST_SEARCH: begin
        line_bad_d = 1'b0;
        vtrk_d     = 1'b0;
        if (v_lead) begin
          state_d = ST_TRACK;
          first_d = 1'b1;
        end
      end
      ST_TRACK: begin
        if (h_lead) begin
          first_d = 1'b0;
          if (h_mismatch && !first_q) line_bad_d = 1'b1;
        end
        if (v_lead) begin
          if (vtrk_q && v_seen_q && !line_bad_q && !(h_mismatch && !first_q) && !v_mismatch) begin
            state_d = ST_LOCKED;
          end else begin
            line_bad_d = 1'b0;
            if (v_seen_q) vtrk_d = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (h_mismatch || v_mismatch || timeout_err) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      line_bad_q <= 1'b0;
      first_q    <= 1'b0;
      vtrk_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_bad_q <= line_bad_d;
      first_q    <= first_d;
      vtrk_q     <= vtrk_d;
      locked_q   <= (state_q == ST_LOCKED);
    end
  end

  assign h_total      = h_total_q;
  assign h_sync_len   = h_sync_len_q;
  assign v_total      = v_total_q;
  assign v_sync_len   = v_sync_len_q;
  assign hpos         = hcnt_q;
  assign vpos         = vcnt_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign timeout_err  = (&hcnt_q) | (&vcnt_q);
  assign lock_state_o = state_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor: an active-high instance and an
// active-low instance driven with inverted sync, both checked against constants.
module tb_vga_sync_monitor;
  logic clk = 1'b0;
  logic rst, pix_en, hsync, vsync;
  logic hsync_n, vsync_n;
  assign hsync_n = ~hsync;
  assign vsync_n = ~vsync;

  logic [10:0] p_h_total, p_h_sync_len, p_hpos, n_h_total, n_h_sync_len, n_hpos;
  logic [9:0]  p_v_total, p_v_sync_len, p_vpos, n_v_total, n_v_sync_len, n_vpos;
  logic        p_line_start, p_frame_start, p_locked, p_timeout_err;
  logic        n_line_start, n_frame_start, n_locked, n_timeout_err;
  logic [1:0]  p_state, n_state;

  int n_checks = 0;
  int n_fail   = 0;

  vga_sync_monitor #(.H_W(11), .V_W(10), .SYNC_ACTIVE_HIGH(1'b1)) dut_p (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync), .vsync_in(vsync),
    .h_total(p_h_total), .h_sync_len(p_h_sync_len), .v_total(p_v_total),
    .v_sync_len(p_v_sync_len), .hpos(p_hpos), .vpos(p_vpos),
    .line_start(p_line_start), .frame_start(p_frame_start), .locked(p_locked),
    .timeout_err(p_timeout_err), .lock_state_o(p_state)
  );

  vga_sync_monitor #(.H_W(11), .V_W(10), .SYNC_ACTIVE_HIGH(1'b0)) dut_n (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_n), .vsync_in(vsync_n),
    .h_total(n_h_total), .h_sync_len(n_h_sync_len), .v_total(n_v_total),
    .v_sync_len(n_v_sync_len), .hpos(n_hpos), .vpos(n_vpos),
    .line_start(n_line_start), .frame_start(n_frame_start), .locked(n_locked),
    .timeout_err(n_timeout_err), .lock_state_o(n_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Event recorder: cycle stamps of pulses and lock transitions.
  int cyc = 0, last_ls_p = 0, rise_p = 0, rise_n = 0, fall_p = 0, fall_ls_p = 0;
  logic lk_prev_p = 1'b0, lk_prev_n = 1'b0, to_prev_p = 1'b0, to_fall_ls_p = 1'b0;
  int fs_cyc_p[$];
  int fs_cyc_n[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (p_line_start === 1'b1) last_ls_p <= cyc;
    if (p_frame_start === 1'b1) fs_cyc_p.push_back(cyc);
    if (n_frame_start === 1'b1) fs_cyc_n.push_back(cyc);
    if (p_locked === 1'b1 && !lk_prev_p) rise_p <= cyc;
    if (n_locked === 1'b1 && !lk_prev_n) rise_n <= cyc;
    if (p_locked === 1'b0 && lk_prev_p) begin
      fall_p    <= cyc;
      fall_ls_p <= last_ls_p;
    end
    if (p_timeout_err === 1'b0 && to_prev_p) to_fall_ls_p <= p_line_start;
    lk_prev_p <= (p_locked === 1'b1);
    lk_prev_n <= (n_locked === 1'b1);
    to_prev_p <= (p_timeout_err === 1'b1);
  end

  // driver tasks
  task automatic tick(input int div);
    for (int i = 0; i < div; i++) begin
      pix_en = (i == div - 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_line(input int div, input int tot, input int sl, input logic vs);
    hsync = 1'b1;
    vsync = vs;
    repeat (sl) tick(div);
    hsync = 1'b0;
    repeat (tot - sl) tick(div);
  endtask

  task automatic send_frame(input int h_tot, input int h_sl, input int v_tot, input int v_sl);
    for (int l = 0; l < v_tot; l++) send_line(1, h_tot, h_sl, (l < v_sl));
  endtask

  task automatic do_reset();
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if ({p_h_total, p_h_sync_len, p_v_total, p_v_sync_len, p_hpos, p_vpos, p_line_start, p_frame_start, p_locked, p_timeout_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_p: h_total=%0d h_sync_len=%0d v_total=%0d hpos=%0d vpos=%0d locked=%b timeout=%b, required all 0", p_h_total, p_h_sync_len, p_v_total, p_hpos, p_vpos, p_locked, p_timeout_err);
    end
    n_checks++;
    if ({n_h_total, n_h_sync_len, n_v_total, n_v_sync_len, n_hpos, n_vpos, n_line_start, n_frame_start, n_locked, n_timeout_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_n: h_total=%0d hpos=%0d locked=%b timeout=%b, required all 0", n_h_total, n_hpos, n_locked, n_timeout_err);
    end
    n_checks++;
    if (p_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", p_state); end
    rst = 1'b0;
  endtask

  task automatic test_single_edge();
    pix_en = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    hsync = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (p_line_start !== (k == 3)) begin
        n_fail++; $display("FAIL edge_latency clk %0d: line_start=%b required %b", k, p_line_start, (k == 3));
      end
      if (k == 3) begin
        n_checks++;
        if (p_hpos !== 11'd0) begin n_fail++; $display("FAIL edge_hpos: got %0d required 0", p_hpos); end
        n_checks++;
        if (n_line_start !== 1'b1) begin n_fail++; $display("FAIL edge_latency_n: line_start=%b required 1", n_line_start); end
      end
    end
    n_checks++;
    if (p_h_total !== 11'd0) begin n_fail++; $display("FAIL first_edge_h_total: got %0d required 0", p_h_total); end
    hsync = 1'b0;
  endtask

  task automatic test_h_timing();
    do_reset();
    send_line(6, 1056, 128, 1'b0);
    n_checks++;
    if (p_h_total !== 11'd0) begin n_fail++; $display("FAIL h_total_after_one_edge: got %0d required 0", p_h_total); end
    n_checks++;
    if (p_h_sync_len !== 11'd128) begin n_fail++; $display("FAIL h_sync_len_first: got %0d required 128", p_h_sync_len); end
    send_line(6, 1056, 128, 1'b0);
    n_checks++;
    if (p_h_total !== 11'd1056) begin n_fail++; $display("FAIL h_total_p: got %0d required 1056", p_h_total); end
    n_checks++;
    if (n_h_total !== 11'd1056) begin n_fail++; $display("FAIL h_total_n: got %0d required 1056", n_h_total); end
    n_checks++;
    if (n_h_sync_len !== 11'd128) begin n_fail++; $display("FAIL h_sync_len_n: got %0d required 128", n_h_sync_len); end
    n_checks++;
    if (p_hpos !== 11'd1055) begin n_fail++; $display("FAIL hpos_end_of_line: got %0d required 1055", p_hpos); end
    n_checks++;
    if (p_vpos !== 10'd2) begin n_fail++; $display("FAIL vpos_two_lines: got %0d required 2", p_vpos); end
  endtask

  task automatic test_lock();
    int base;
    do_reset();
    base = fs_cyc_p.size();
    repeat (3) send_frame(6, 2, 628, 4);
    n_checks++;
    if (p_v_total !== 10'd628) begin n_fail++; $display("FAIL v_total_p: got %0d required 628", p_v_total); end
    n_checks++;
    if (n_v_total !== 10'd628) begin n_fail++; $display("FAIL v_total_n: got %0d required 628", n_v_total); end
    n_checks++;
    if (p_v_sync_len !== 10'd4) begin n_fail++; $display("FAIL v_sync_len_p: got %0d required 4", p_v_sync_len); end
    n_checks++;
    if (n_v_sync_len !== 10'd4) begin n_fail++; $display("FAIL v_sync_len_n: got %0d required 4", n_v_sync_len); end
    n_checks++;
    if (fs_cyc_p.size() != base + 3) begin n_fail++; $display("FAIL frame_start_count: got %0d required %0d", fs_cyc_p.size() - base, 3); end
    n_checks++;
    if (p_locked !== 1'b1 || p_state !== 2'd2) begin n_fail++; $display("FAIL locked_p: locked=%b state=%0d required 1/2", p_locked, p_state); end
    n_checks++;
    if (rise_p != fs_cyc_p[base + 2] + 1) begin n_fail++; $display("FAIL lock_timing_p: rise at %0d required %0d", rise_p, fs_cyc_p[base + 2] + 1); end
    n_checks++;
    if (rise_n != fs_cyc_n[base + 2] + 1) begin n_fail++; $display("FAIL lock_timing_n: rise at %0d required %0d", rise_n, fs_cyc_n[base + 2] + 1); end
  endtask

  task automatic test_line_glitch();
    int base;
    for (int l = 0; l < 628; l++) begin
      send_line(1, (l == 300) ? 7 : 6, 2, (l < 4));
      if (l == 301) begin
        n_checks++;
        if (p_h_total !== 11'd7) begin n_fail++; $display("FAIL long_line_h_total: got %0d required 7", p_h_total); end
        n_checks++;
        if (p_locked !== 1'b0) begin n_fail++; $display("FAIL unlock_on_long_line: locked=%b required 0", p_locked); end
      end
    end
    n_checks++;
    if (fall_p != fall_ls_p + 1) begin n_fail++; $display("FAIL unlock_timing: fall at %0d required %0d", fall_p, fall_ls_p + 1); end
    base = fs_cyc_p.size();
    repeat (3) send_frame(6, 2, 628, 4);
    n_checks++;
    if (p_locked !== 1'b1) begin n_fail++; $display("FAIL relock: locked=%b required 1", p_locked); end
    n_checks++;
    if (rise_p != fs_cyc_p[base + 2] + 1) begin n_fail++; $display("FAIL relock_timing: rise at %0d required %0d", rise_p, fs_cyc_p[base + 2] + 1); end
  endtask

  task automatic test_timeout();
    hsync = 1'b0;
    for (int i = 0; i < 2300 && p_timeout_err !== 1'b1; i++) tick(1);
    n_checks++;
    if (p_timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_rise: timeout_err=%b required 1 within budget", p_timeout_err); end
    n_checks++;
    if (p_hpos !== 11'd2047) begin n_fail++; $display("FAIL timeout_hpos: got %0d required 2047", p_hpos); end
    repeat (3) tick(1);
    n_checks++;
    if (p_locked !== 1'b0) begin n_fail++; $display("FAIL timeout_unlock: locked=%b required 0", p_locked); end
    n_checks++;
    if (n_timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_n: timeout_err=%b required 1", n_timeout_err); end
    send_line(1, 6, 2, 1'b0);
    n_checks++;
    if (p_timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: timeout_err=%b required 0", p_timeout_err); end
    n_checks++;
    if (to_fall_ls_p !== 1'b1) begin n_fail++; $display("FAIL timeout_clear_on_edge: line_start at clear=%b required 1", to_fall_ls_p); end
  endtask

  task automatic test_reset_mid();
    for (int l = 0; l < 100; l++) send_line(1, 6, 2, (l < 4));
    hsync = 1'b1; repeat (2) tick(1);
    hsync = 1'b0; repeat (2) tick(1);
    rst = 1'b1; pix_en = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({p_h_total, p_h_sync_len, p_v_total, p_v_sync_len, p_hpos, p_vpos, p_line_start, p_frame_start, p_locked, p_timeout_err, p_state} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: h_total=%0d v_total=%0d hpos=%0d vpos=%0d state=%0d, required all 0", p_h_total, p_v_total, p_hpos, p_vpos, p_state);
    end
    rst = 1'b0;
    send_line(1, 1056, 128, 1'b0);
    n_checks++;
    if (p_h_total !== 11'd0) begin n_fail++; $display("FAIL post_reset_first_edge: h_total=%0d required 0", p_h_total); end
    send_line(1, 1056, 128, 1'b0);
    n_checks++;
    if (p_h_total !== 11'd1056) begin n_fail++; $display("FAIL post_reset_second_edge: h_total=%0d required 1056", p_h_total); end
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0;
    test_reset();
    test_single_edge();
    test_h_timing();
    test_lock();
    test_line_glitch();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
